// File: rtl/mp64_muldiv_if.sv
// Handshake/bus bundle for mp64_muldiv.
// master: drives start/kill/op/a/b/flags_in and observes busy/done/result/flags_out.
// slave : the multiply/divide unit itself.
interface mp64_muldiv_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             kill;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [7:0]       flags_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [7:0]       flags_out;

  modport master (
    output start, kill, op, a, b, flags_in,
    input  busy, done, result, flags_out
  );

  modport slave (
    input  start, kill, op, a, b, flags_in,
    output busy, done, result, flags_out
  );
endinterface

// File: rtl/mp64_muldiv.sv
// Multi-cycle multiply/divide unit, one bit per clock over a WIDTH-bit datapath.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   bus      - mp64_muldiv_if.slave: start/kill/op/a/b/flags_in in,
//              busy/done/result/flags_out out (all outputs registered)
// Ops: 0 MUL, 1 MULH, 2 MULHS, 3 DIV, 4 DIVS, 5 MOD, 6 MODS, 7 reserved.
// flags_out: Z[0] C[1] N[2] V[3] P[4] G[5], [7:6] latched from flags_in.
module mp64_muldiv #(
  parameter int unsigned WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  mp64_muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHS = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVS  = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_MODS  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       fhi_q, fhi_d;
  logic             negq_q, negq_d;   // quotient / product sign
  logic             negr_q, negr_d;   // remainder sign (dividend sign)
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d;   // untouched dividend for divide-by-zero remainder
  logic [W2-1:0]    acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [7:0]       flags_q, flags_d;

  // Flag bits [5:0] are recomputed here, never passed through.
  logic unused_flags;
  assign unused_flags = ^bus.flags_in[5:0];

  // Operand decode at issue.
  logic             signed_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_sel, b_sel;
  assign signed_op = (bus.op == OP_MULHS) || (bus.op == OP_DIVS) || (bus.op == OP_MODS);
  assign div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVS) ||
                     (bus.op == OP_MOD) || (bus.op == OP_MODS);
  assign a_neg     = signed_op && bus.a[WIDTH-1];
  assign b_neg     = signed_op && bus.b[WIDTH-1];
  assign a_sel     = a_neg ? -bus.a : bus.a;
  assign b_sel     = b_neg ? -bus.b : bus.b;

  logic op_q_div;
  assign op_q_div = (op_q == OP_DIV) || (op_q == OP_DIVS) ||
                    (op_q == OP_MOD) || (op_q == OP_MODS);

  // One shift-add multiply step: conditional add into the high half, then shift right.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step on {remainder, quotient} shifted left by one.
  logic [WIDTH:0]  trial;
  logic [W2-1:0]   div_next;
  assign trial    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
  assign div_next = trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Final sign fixup and half selection.
  logic [WIDTH-1:0] lo_half, hi_half, neg_hi;
  assign lo_half = acc_q[WIDTH-1:0];
  assign hi_half = acc_q[W2-1:WIDTH];
  // High half of the negated double-width product: carry in only when the low half is zero.
  assign neg_hi  = ~hi_half + WIDTH'(lo_half == '0);

  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v;
  logic [7:0]       fin_flags;

  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    case (op_q)
      OP_MUL: begin
        fin_res = lo_half;
        fin_c   = |hi_half;
        fin_v   = |hi_half;
      end
      OP_MULH:  fin_res = hi_half;
      OP_MULHS: fin_res = negq_q ? neg_hi : hi_half;
      OP_DIV: begin
        fin_res = dz_q ? '1 : lo_half;
        fin_v   = dz_q;
      end
      OP_DIVS: begin
        fin_res = dz_q ? '1 : (negq_q ? -lo_half : lo_half);
        fin_v   = dz_q | ovf_q;
      end
      OP_MOD: begin
        fin_res = dz_q ? araw_q : hi_half;
        fin_v   = dz_q;
      end
      OP_MODS: begin
        fin_res = dz_q ? araw_q : (negr_q ? -hi_half : hi_half);
        fin_v   = dz_q | ovf_q;
      end
      default: fin_res = '0;
    endcase
    if (op_q == OP_RSVD) begin
      fin_flags = {fhi_q, 6'b000001};
    end else begin
      fin_flags = {fhi_q, 1'b0, ~^fin_res[7:0], fin_v, fin_res[WIDTH-1], fin_c,
                   (fin_res == '0)};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      fhi_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      m_q      <= '0;
      araw_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      fhi_q    <= fhi_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      m_q      <= m_d;
      araw_q   <= araw_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    fhi_d    = fhi_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    m_d      = m_q;
    araw_d   = araw_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      IDLE: begin
        // A same-cycle kill suppresses the start.
        if (bus.start && !bus.kill) begin
          op_d   = bus.op;
          fhi_d  = bus.flags_in[7:6];
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          araw_d = bus.a;
          dz_d   = div_op && (bus.b == '0);
          ovf_d  = ((bus.op == OP_DIVS) || (bus.op == OP_MODS)) &&
                   (bus.a == MIN_VAL) && (bus.b == '1);
          cnt_d  = CNT_W'(WIDTH);
          busy_d = 1'b1;
          if (div_op) begin
            m_d   = b_sel;
            acc_d = {{WIDTH{1'b0}}, a_sel};
          end else begin
            m_d   = a_sel;
            acc_d = {{WIDTH{1'b0}}, b_sel};
          end
          if ((div_op && (bus.b == '0)) || (bus.op == OP_RSVD)) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = op_q_div ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (!bus.kill) begin
          result_d = fin_res;
          flags_d  = fin_flags;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_mp64_muldiv.sv
// Self-checking bench for mp64_muldiv: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mp64_muldiv;

  localparam int unsigned WIDTH = 64;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV  = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;
  logic [63:0] last_res;
  logic [7:0]  last_fl;

  mp64_muldiv_if #(.WIDTH(WIDTH)) bus ();

  mp64_muldiv #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {flags, result} from plain arithmetic.
  function automatic logic [71:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [7:0] fi);
    logic [127:0]        p;
    logic signed [63:0]  sa, sb, sq;
    logic signed [127:0] ea, eb, sp;
    logic [63:0]         r;
    logic                c, v;
    sa = a;
    sb = b;
    ea = sa;
    eb = sb;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    p  = {64'd0, a} * {64'd0, b};
    case (op)
      3'd0: begin r = p[63:0]; c = (p[127:64] != 64'd0); v = c; end
      3'd1: r = p[127:64];
      3'd2: begin sp = ea * eb; r = sp[127:64]; end
      3'd3: begin
        if (b == 64'd0) begin r = ONES; v = 1'b1; end
        else r = a / b;
      end
      3'd4: begin
        if (b == 64'd0) begin r = ONES; v = 1'b1; end
        else if (a == MINV && b == ONES) begin r = MINV; v = 1'b1; end
        else begin sq = sa / sb; r = sq; end
      end
      3'd5: begin
        if (b == 64'd0) begin r = a; v = 1'b1; end
        else r = a % b;
      end
      3'd6: begin
        if (b == 64'd0) begin r = a; v = 1'b1; end
        else if (a == MINV && b == ONES) begin r = 64'd0; v = 1'b1; end
        else begin sq = sa % sb; r = sq; end
      end
      default: return {fi[7:6], 6'b000001, 64'd0};
    endcase
    return {fi[7:6], 1'b0, ~^r[7:0], v, r[63], c, (r == 64'd0), r};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 300));
      2:       return MINV;
      3:       return ONES;
      4:       return 64'd0;
      default: return -64'($urandom_range(1, 300));
    endcase
  endfunction

  // Issue one op, optionally intrude a second start or a kill at a given cycle.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] fi, input int intr_cyc, input int kill_cyc,
                        output logic [63:0] got_res, output logic [7:0] got_fl);
    logic [71:0] e;
    int cyc, bcnt, lat, dn;
    e   = model(op, a, b, fi);
    lat = ((op == 3'd7) || (op >= 3'd3 && b == 64'd0)) ? 1 : WIDTH + 1;
    bus.op = op; bus.a = a; bus.b = b; bus.flags_in = fi; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    cyc  = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (cyc == intr_cyc) begin
        bus.start = 1'b1;
        bus.op = 3'($urandom);
        bus.flags_in = 8'($urandom);
      end
      if (cyc == kill_cyc) bus.kill = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc++;
      if (bus.kill === 1'b1) begin
        bus.kill = 1'b0;
        chk("kill_busy", 128'(bus.busy), 128'd0);
        chk("kill_done", 128'(bus.done), 128'd0);
        dn = 0;
        repeat (WIDTH + 4) begin
          tick();
          if (bus.done === 1'b1) dn++;
        end
        chk("kill_no_done", 128'(dn), 128'd0);
        chk("kill_result_kept", 128'(bus.result), 128'(last_res));
        chk("kill_flags_kept", 128'(bus.flags_out), 128'(last_fl));
        got_res = bus.result;
        got_fl  = bus.flags_out;
        return;
      end
      if (bus.busy === 1'b1) bcnt++;
    end
    chk("done_seen", 128'(bus.done), 128'd1);
    chk("latency", 128'(cyc), 128'(lat));
    chk("busy_cycles", 128'(bcnt), 128'(lat));
    chk("busy_at_done", 128'(bus.busy), 128'd0);
    chk("result", 128'(bus.result), 128'(e[63:0]));
    chk("flags", 128'(bus.flags_out), 128'(e[71:64]));
    got_res  = bus.result;
    got_fl   = bus.flags_out;
    last_res = e[63:0];
    last_fl  = e[71:64];
    tick();
    chk("done_pulse", 128'(bus.done), 128'd0);
    chk("result_hold", 128'(bus.result), 128'(e[63:0]));
  endtask

  initial begin
    logic [63:0] r;
    logic [7:0]  f;
    rst = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0;
    bus.a = '0; bus.b = '0; bus.flags_in = '0;
    last_res = '0;
    last_fl  = '0;
    tick();
    tick();
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_result", 128'(bus.result), 128'd0);
    chk("rst_flags", 128'(bus.flags_out), 128'd0);
    rst = 1'b0;
    tick();

    run_op(3'd0, ONES, 64'd2, 8'h00, -1, -1, r, f);
    chk("mul_res", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFE));
    chk("mul_fl", 128'(f), 128'(8'h0E));
    run_op(3'd1, ONES, ONES, 8'h00, -1, -1, r, f);
    chk("mulh_res", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFE));
    run_op(3'd2, ONES, ONES, 8'hC0, -1, -1, r, f);
    chk("mulhs_res", 128'(r), 128'd0);
    chk("mulhs_fl", 128'(f), 128'(8'hD1));
    run_op(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 8'h00, -1, -1, r, f);
    chk("divs_res", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFD));
    run_op(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 8'h00, -1, -1, r, f);
    chk("mods_res", 128'(r), 128'(ONES));
    chk("mods_fl", 128'(f), 128'(8'h14));
    run_op(3'd3, 64'd100, 64'd7, 8'h00, -1, -1, r, f);
    chk("div_res", 128'(r), 128'd14);
    chk("div_fl", 128'(f), 128'(8'h00));
    run_op(3'd5, 64'd100, 64'd7, 8'h00, -1, -1, r, f);
    chk("mod_res", 128'(r), 128'd2);
    run_op(3'd3, 64'd100, 64'd0, 8'h00, -1, -1, r, f);
    chk("div0_res", 128'(r), 128'(ONES));
    chk("div0_fl", 128'(f), 128'(8'h1C));
    run_op(3'd5, 64'd100, 64'd0, 8'h00, -1, -1, r, f);
    chk("mod0_res", 128'(r), 128'd100);
    chk("mod0_fl", 128'(f), 128'(8'h08));
    run_op(3'd4, MINV, ONES, 8'h00, -1, -1, r, f);
    chk("divs_ovf_res", 128'(r), 128'(MINV));
    chk("divs_ovf_fl", 128'(f), 128'(8'h1C));
    run_op(3'd7, 64'd5, 64'd9, 8'h80, -1, -1, r, f);
    chk("rsvd_fl", 128'(f), 128'(8'h81));

    // Second start mid-run is ignored.
    run_op(3'd3, 64'd1000, 64'd3, 8'h40, 10, -1, r, f);
    chk("intrude_res", 128'(r), 128'd333);

    // Kill at cycle 30 keeps the previous result.
    run_op(3'd0, 64'd12345, 64'd678, 8'h00, -1, 30, r, f);

    // Kill beats a same-cycle start in IDLE.
    bus.op = 3'd0; bus.start = 1'b1; bus.kill = 1'b1;
    tick();
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_start_busy", 128'(bus.busy), 128'd0);

    // Asynchronous reset mid-run.
    bus.op = 3'd1; bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_result", 128'(bus.result), 128'd0);
    chk("midrst_flags", 128'(bus.flags_out), 128'd0);
    tick();
    rst = 1'b0;
    last_res = '0;
    last_fl  = '0;
    tick();
    run_op(3'd0, 64'd7, 64'd6, 8'h00, -1, -1, r, f);
    chk("post_rst_res", 128'(r), 128'd42);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 8'($urandom), -1, -1, r, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
